wb_mgmt_arbiter: RTL

- Two-master, round-robin arbiter for the management Wishbone bus, single-transaction mode (non-pipelined).
- Lets the power-on initializer (M0) and a host/debug master (M1) share the chip-selected slaves (CSel[0] = SGMII core, CSel[1] = MDIO master).
- Adds a per-transaction ack watchdog and rejects illegal chip selects, so a dead slave or a bad access cannot hang the bus.
- Sits between the masters and the existing Cyc/Stb/WEn/CSel fan-out on the GMII clock domain.

---
 rtl/wb_mgmt_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_mgmt_arbiter.sv
// wb_mgmt_arbiter
//   Two-master round-robin arbiter for the management Wishbone bus
//   (single-transaction, non-pipelined). M0 is the power-on initializer,
//   M1 the host/debug master. Adds a per-transaction ack watchdog and
//   rejects illegal chip selects so a dead slave or bad access cannot
//   hang the bus.
//
// Ports
//   i_Clk, i_Rst_L            management clock, synchronous active-low reset
//   i_MxCyc/Stb/WEn           master bus controls (x = 0, 1)
//   i2_MxCSel                 master one-hot chip select
//   i8_MxAddr, i32_MxWrData   master address / write data
//   o_MxAck, o_MxErr          master terminations
//   o32_MxRdData              read data to master (0 unless granted)
//   o_Cyc/Stb/WEn, o2_CSel    slave-side controls
//   o8_Addr, o32_WrData       slave-side address / write data
//   i_Ack, i32_RdData         OR of slave acks, slave read data mux
//   o2_Grant                  one-hot current owner (status)
//   o_TimeoutEvt              one-cycle pulse per watchdog abort
//
// State      | meaning
// IDLE       | no owner, arbitrate on the Cyc inputs
// GNT0       | M0 owns the bus, slave side follows M0
// GNT1       | M1 owns the bus, slave side follows M1
// ILLERR     | illegal chip select seen, Err pulse to owner
// ABORT      | watchdog expired, Err + TimeoutEvt pulse to owner
// WAITDROP   | slave side idle, wait for the owner to drop Cyc

module wb_mgmt_arbiter #(
    parameter int P_TIMEOUT = 255,
    parameter int P_TOW     = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_M0Cyc,
    input  logic        i_M1Cyc,
    input  logic        i_M0Stb,
    input  logic        i_M1Stb,
    input  logic        i_M0WEn,
    input  logic        i_M1WEn,
    input  logic [1:0]  i2_M0CSel,
    input  logic [1:0]  i2_M1CSel,
    input  logic [7:0]  i8_M0Addr,
    input  logic [7:0]  i8_M1Addr,
    input  logic [31:0] i32_M0WrData,
    input  logic [31:0] i32_M1WrData,
    output logic        o_M0Ack,
    output logic        o_M1Ack,
    output logic        o_M0Err,
    output logic        o_M1Err,
    output logic [31:0] o32_M0RdData,
    output logic [31:0] o32_M1RdData,
    output logic        o_Cyc,
    output logic        o_Stb,
    output logic        o_WEn,
    output logic [1:0]  o2_CSel,
    output logic [7:0]  o8_Addr,
    output logic [31:0] o32_WrData,
    input  logic        i_Ack,
    input  logic [31:0] i32_RdData,
    output logic [1:0]  o2_Grant,
    output logic        o_TimeoutEvt
);

    typedef enum logic [2:0] {
        IDLE, GNT0, GNT1, ILLERR, ABORT, WAITDROP
    } state_t;

    state_t           rState, nState;
    logic             rOwner, nOwner;   // 0 = M0, 1 = M1
    logic             rPtr, nPtr;       // round-robin pointer, 0 = M0
    logic [P_TOW-1:0] rWdog, nWdog;

    logic        sCyc, sStb, sWEn, sLegal, sBad;
    logic [1:0]  sCSel;
    logic [7:0]  sAddr;
    logic [31:0] sWrData;
    logic        ackSel, errSel;
    logic [31:0] rdSel;

    // Owner's signals, valid whenever rOwner is meaningful (non-IDLE)
    assign sCyc    = rOwner ? i_M1Cyc      : i_M0Cyc;
    assign sStb    = rOwner ? i_M1Stb      : i_M0Stb;
    assign sWEn    = rOwner ? i_M1WEn      : i_M0WEn;
    assign sCSel   = rOwner ? i2_M1CSel    : i2_M0CSel;
    assign sAddr   = rOwner ? i8_M1Addr    : i8_M0Addr;
    assign sWrData = rOwner ? i32_M1WrData : i32_M0WrData;
    assign sLegal  = (sCSel == 2'b01) || (sCSel == 2'b10);
    assign sBad    = sStb && !sLegal;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            rState <= IDLE;
            rOwner <= 1'b0;
            rPtr   <= 1'b0;
            rWdog  <= '0;
        end else begin
            rState <= nState;
            rOwner <= nOwner;
            rPtr   <= nPtr;
            rWdog  <= nWdog;
        end
    end

    always_comb begin
        nState       = rState;
        nOwner       = rOwner;
        nPtr         = rPtr;
        nWdog        = '0;
        o_Cyc        = 1'b0;
        o_Stb        = 1'b0;
        o_WEn        = 1'b0;
        o2_CSel      = 2'b00;
        o8_Addr      = 8'h00;
        o32_WrData   = 32'h0;
        ackSel       = 1'b0;
        errSel       = 1'b0;
        rdSel        = 32'h0;
        o2_Grant     = 2'b00;
        o_TimeoutEvt = 1'b0;
        case (rState)
            IDLE: begin
                if (i_M0Cyc && i_M1Cyc) begin
                    nOwner = rPtr;
                    nPtr   = ~rPtr;
                    nState = rPtr ? GNT1 : GNT0;
                end else if (i_M0Cyc) begin
                    nOwner = 1'b0;
                    nState = GNT0;
                end else if (i_M1Cyc) begin
                    nOwner = 1'b1;
                    nState = GNT1;
                end
            end
            GNT0, GNT1: begin
                o2_Grant   = rOwner ? 2'b10 : 2'b01;
                o_Cyc      = sCyc && !sBad;
                o_Stb      = sStb && !sBad;
                o_WEn      = sWEn;
                o2_CSel    = sCSel;
                o8_Addr    = sAddr;
                o32_WrData = sWrData;
                ackSel     = i_Ack && sStb && sLegal;
                rdSel      = i32_RdData;
                if (!sCyc) begin
                    nState = IDLE;
                end else if (sBad) begin
                    nState = ILLERR;
                end else if (sStb && !i_Ack) begin
                    // Ack on the terminal cycle wins: this branch is skipped
                    if (rWdog == P_TOW'(P_TIMEOUT - 1))
                        nState = ABORT;
                    else
                        nWdog = rWdog + P_TOW'(1);
                end
            end
            ILLERR: begin
                o2_Grant = rOwner ? 2'b10 : 2'b01;
                errSel   = 1'b1;
                nState   = WAITDROP;
            end
            ABORT: begin
                o2_Grant     = rOwner ? 2'b10 : 2'b01;
                errSel       = 1'b1;
                o_TimeoutEvt = 1'b1;
                nState       = WAITDROP;
            end
            WAITDROP: begin
                // late slave acks land here and are dropped
                o2_Grant = rOwner ? 2'b10 : 2'b01;
                if (!sCyc)
                    nState = IDLE;
            end
            default: nState = IDLE;
        endcase
    end

    assign o_M0Ack      = ackSel && !rOwner;
    assign o_M1Ack      = ackSel &&  rOwner;
    assign o_M0Err      = errSel && !rOwner;
    assign o_M1Err      = errSel &&  rOwner;
    assign o32_M0RdData = rOwner ? 32'h0 : rdSel;
    assign o32_M1RdData = rOwner ? rdSel : 32'h0;

endmodule
